arp_frame_collector: RTL and testbench

Synthesizable receive-side frame collector for the ARP/Ethernet frame interface. It accepts an Ethernet header handshake plus an 8-bit AXI-stream payload and packs them into one flat 336-bit frame word: 112-bit header followed by a 28-byte ARP payload. The word is presented on a single valid/ready output for the DPI/host side. It attaches to the `m_eth_*` output of the ARP core and is the counterpart of the flat-vector-to-stream serializer on the transmit path.

---
 rtl/arp_frame_collector.sv | 134 +++++++++++++
 tb/tb_arp_frame_collector.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_frame_collector.sv
// Collects an Ethernet header plus an 8-bit ARP payload stream into one flat
// frame word with length and error status, presented on a valid/ready output.
module arp_frame_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int PAYLOAD_BYTES = 28,
  localparam int TOTAL_WIDTH = 112 + 8 * PAYLOAD_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_eth_hdr_valid,
  output logic                   s_eth_hdr_ready,
  input  logic [47:0]            s_eth_dest_mac,
  input  logic [47:0]            s_eth_src_mac,
  input  logic [15:0]            s_eth_type,
  input  logic [DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
  input  logic                   s_eth_payload_axis_tvalid,
  output logic                   s_eth_payload_axis_tready,
  input  logic                   s_eth_payload_axis_tlast,
  input  logic                   s_eth_payload_axis_tuser,
  output logic                   m_frame_valid,
  input  logic                   m_frame_ready,
  output logic [TOTAL_WIDTH-1:0] m_frame_data,
  output logic [5:0]             m_frame_len,
  output logic [2:0]             m_frame_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  state_t                   state_q, state_d;
  logic [TOTAL_WIDTH-1:0]   data_q, data_d;
  logic [5:0]               len_q, len_d;
  logic [2:0]               err_q, err_d;
  logic                     beat;
  logic [6:0]               len_inc;
  logic [PAYLOAD_BYTES-1:0] lane_sel;

  // Ready/valid are pure decodes of the state register: no input-to-output paths.
  assign s_eth_hdr_ready           = (state_q == ST_IDLE);
  assign s_eth_payload_axis_tready = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
  assign m_frame_valid             = (state_q == ST_OUTPUT);
  assign m_frame_data              = data_q;
  assign m_frame_len               = len_q;
  assign m_frame_error             = err_q;

  assign beat    = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign len_inc = {1'b0, len_q} + 7'd1;

  // One-hot byte lane select: payload byte i lands at bits [223-8i -: 8].
  for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_lane
    assign lane_sel[gi] = (len_q == 6'(gi));
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (s_eth_hdr_valid) begin
          data_d = '0;
          data_d[TOTAL_WIDTH-1 -: 112] = {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
          len_d   = '0;
          err_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (beat) begin
          for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (lane_sel[i]) begin
              data_d[8*(PAYLOAD_BYTES-1-i) +: 8] = s_eth_payload_axis_tdata;
            end
          end
          len_d = len_inc[5:0];
          if (s_eth_payload_axis_tuser) begin
            err_d[0] = 1'b1;
          end
          if (s_eth_payload_axis_tlast) begin
            if (len_inc < 7'(PAYLOAD_BYTES)) begin
              err_d[1] = 1'b1;
            end
            state_d = ST_OUTPUT;
          end else if (len_inc == 7'(PAYLOAD_BYTES)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Overlong tail: bytes are dropped but still counted (saturating).
        if (beat) begin
          err_d[2] = 1'b1;
          if (len_q != 6'd63) begin
            len_d = len_inc[5:0];
          end
          if (s_eth_payload_axis_tuser) begin
            err_d[0] = 1'b1;
          end
          if (s_eth_payload_axis_tlast) begin
            state_d = ST_OUTPUT;
          end
        end
      end
      ST_OUTPUT: begin
        if (m_frame_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      len_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_arp_frame_collector.sv
// Bench for arp_frame_collector: randomized frames checked against a
// frame-level model of packing, length and error flags.
module tb_arp_frame_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_eth_hdr_valid = 1'b0;
  logic         s_eth_hdr_ready;
  logic [47:0]  s_eth_dest_mac = '0;
  logic [47:0]  s_eth_src_mac = '0;
  logic [15:0]  s_eth_type = '0;
  logic [7:0]   tdata = '0;
  logic         tvalid = 1'b0;
  logic         tready;
  logic         tlast = 1'b0;
  logic         tuser = 1'b0;
  logic         m_frame_valid;
  logic         m_frame_ready = 1'b1;
  logic [335:0] m_frame_data;
  logic [5:0]   m_frame_len;
  logic [2:0]   m_frame_error;

  arp_frame_collector dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_eth_hdr_valid           (s_eth_hdr_valid),
    .s_eth_hdr_ready           (s_eth_hdr_ready),
    .s_eth_dest_mac            (s_eth_dest_mac),
    .s_eth_src_mac             (s_eth_src_mac),
    .s_eth_type                (s_eth_type),
    .s_eth_payload_axis_tdata  (tdata),
    .s_eth_payload_axis_tvalid (tvalid),
    .s_eth_payload_axis_tready (tready),
    .s_eth_payload_axis_tlast  (tlast),
    .s_eth_payload_axis_tuser  (tuser),
    .m_frame_valid             (m_frame_valid),
    .m_frame_ready             (m_frame_ready),
    .m_frame_data              (m_frame_data),
    .m_frame_len               (m_frame_len),
    .m_frame_error             (m_frame_error)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  logic drv_to = 1'b0;
  logic drv_done = 1'b0;

  // Frame table: header, length, tuser beat (0 = none), payload bytes.
  logic [111:0] fr_hdr [8];
  int           fr_n   [8];
  int           fr_tu  [8];
  logic [7:0]   fr_pl  [8][80];
  int           fr_hdr_cyc [8];
  int           fr_tlast_cyc [8];

  logic [335:0] oq_data [$];
  logic [5:0]   oq_len [$];
  logic [2:0]   oq_err [$];
  int           oq_start [$];
  int           oq_hs [$];

  // Output monitor: samples just after the falling edge.
  initial begin
    logic prev_valid;
    int   start;
    prev_valid = 1'b0;
    start = 0;
    forever begin
      @(negedge clk);
      #1;
      if (m_frame_valid && !prev_valid) start = cyc;
      prev_valid = m_frame_valid;
      if (m_frame_valid && m_frame_ready) begin
        oq_data.push_back(m_frame_data);
        oq_len.push_back(m_frame_len);
        oq_err.push_back(m_frame_error);
        oq_start.push_back(start);
        oq_hs.push_back(cyc);
        $display("frame out: cyc=%0d len=%0d err=%b hdr=%h", cyc, m_frame_len, m_frame_error, m_frame_data[335:224]);
      end
    end
  end

  function automatic logic [335:0] model_data(input int s);
    logic [335:0] d;
    d = 336'(fr_hdr[s]);
    for (int i = 0; i < 28; i++) begin
      d = (d << 8) | ((i < fr_n[s]) ? 336'(fr_pl[s][i]) : 336'd0);
    end
    return d;
  endfunction

  function automatic logic [5:0] model_len(input int s);
    return (fr_n[s] > 63) ? 6'd63 : 6'(fr_n[s]);
  endfunction

  function automatic logic [2:0] model_err(input int s);
    return {fr_n[s] > 28, fr_n[s] < 28, (fr_tu[s] >= 1) && (fr_tu[s] <= fr_n[s])};
  endfunction

  task automatic rand_frame(input int s, input int n, input int tu);
    fr_hdr[s] = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
    fr_n[s]   = n;
    fr_tu[s]  = tu;
    for (int i = 0; i < 80; i++) fr_pl[s][i] = 8'($urandom_range(255));
  endtask

  task automatic clear_queues();
    oq_data.delete(); oq_len.delete(); oq_err.delete(); oq_start.delete(); oq_hs.delete();
    drv_to = 1'b0;
  endtask

  task automatic send_frame(input int s, input int gap_pct, input int stop_after);
    int t;
    @(negedge clk);
    s_eth_hdr_valid = 1'b1;
    {s_eth_dest_mac, s_eth_src_mac, s_eth_type} = fr_hdr[s];
    t = 0;
    while (!s_eth_hdr_ready && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) drv_to = 1'b1;
    fr_hdr_cyc[s] = cyc;
    @(negedge clk);
    s_eth_hdr_valid = 1'b0;
    for (int b = 1; b <= fr_n[s]; b++) begin
      if (stop_after > 0 && b > stop_after) break;
      while ($urandom_range(99) < gap_pct) begin tvalid = 1'b0; @(negedge clk); end
      tvalid = 1'b1;
      tdata  = fr_pl[s][b-1];
      tlast  = (b == fr_n[s]);
      tuser  = (b == fr_tu[s]);
      t = 0;
      while (!tready && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) drv_to = 1'b1;
      if (b == fr_n[s]) fr_tlast_cyc[s] = cyc;
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic wait_outputs(input int k);
    for (int t = 0; t < 500 && oq_data.size() < k; t++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (m_frame_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", m_frame_valid); else n_pass++;
    n_chk++; if (tready !== 1'b0) $display("FAIL reset_tready got %b want 0", tready); else n_pass++;
    n_chk++; if (m_frame_data !== 336'd0) $display("FAIL reset_data got %h want 0", m_frame_data); else n_pass++;
    n_chk++; if (m_frame_len !== 6'd0) $display("FAIL reset_len got %0d want 0", m_frame_len); else n_pass++;
    n_chk++; if (m_frame_error !== 3'd0) $display("FAIL reset_err got %b want 000", m_frame_error); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_chk++; if (s_eth_hdr_ready !== 1'b1) $display("FAIL reset_hdr_ready got %b want 1", s_eth_hdr_ready); else n_pass++;
  endtask

  task automatic test_nominal();
    logic [335:0] d;
    clear_queues();
    fr_hdr[0] = {48'hFFFFFFFFFFFF, 48'h5A5152535455, 16'h0806};
    fr_n[0] = 28;
    fr_tu[0] = 0;
    for (int i = 0; i < 80; i++) fr_pl[0][i] = 8'(i);
    m_frame_ready = 1'b1;
    send_frame(0, 0, 0);
    wait_outputs(1);
    n_chk++; if (oq_data.size() != 1) $display("FAIL nominal_count got %0d want 1", oq_data.size()); else n_pass++;
    if (oq_data.size() >= 1) begin
      d = oq_data[0];
      n_chk++; if (d[335:224] !== 112'hFFFFFFFFFFFF5A51525354550806) $display("FAIL nominal_hdr got %h want FFFFFFFFFFFF5A51525354550806", d[335:224]); else n_pass++;
      n_chk++; if (d[223:216] !== 8'h00) $display("FAIL nominal_byte0 got %h want 00", d[223:216]); else n_pass++;
      n_chk++; if (d[7:0] !== 8'h1B) $display("FAIL nominal_byte27 got %h want 1b", d[7:0]); else n_pass++;
      n_chk++; if (d !== model_data(0)) $display("FAIL nominal_data got %h want %h", d, model_data(0)); else n_pass++;
      n_chk++; if (oq_len[0] !== 6'd28) $display("FAIL nominal_len got %0d want 28", oq_len[0]); else n_pass++;
      n_chk++; if (oq_err[0] !== 3'b000) $display("FAIL nominal_err got %b want 000", oq_err[0]); else n_pass++;
      n_chk++; if (oq_start[0] != fr_tlast_cyc[0] + 1) $display("FAIL nominal_latency got %0d want %0d", oq_start[0], fr_tlast_cyc[0] + 1); else n_pass++;
      n_chk++; if (fr_tlast_cyc[0] != fr_hdr_cyc[0] + 28) $display("FAIL nominal_rate got %0d want %0d", fr_tlast_cyc[0], fr_hdr_cyc[0] + 28); else n_pass++;
    end
    n_chk++; if (drv_to !== 1'b0) $display("FAIL nominal_timeout got %b want 0", drv_to); else n_pass++;
  endtask

  task automatic test_short();
    clear_queues();
    rand_frame(0, 20, 0);
    send_frame(0, 0, 0);
    wait_outputs(1);
    n_chk++; if (oq_data.size() != 1) $display("FAIL short_count got %0d want 1", oq_data.size()); else n_pass++;
    if (oq_data.size() >= 1) begin
      n_chk++; if (oq_len[0] !== 6'd20) $display("FAIL short_len got %0d want 20", oq_len[0]); else n_pass++;
      n_chk++; if (oq_err[0] !== 3'b010) $display("FAIL short_err got %b want 010", oq_err[0]); else n_pass++;
      n_chk++; if (oq_data[0] !== model_data(0)) $display("FAIL short_data got %h want %h", oq_data[0], model_data(0)); else n_pass++;
      n_chk++; if (oq_data[0][63:0] !== 64'd0) $display("FAIL short_tail got %h want 0", oq_data[0][63:0]); else n_pass++;
    end
  endtask

  task automatic test_long();
    clear_queues();
    rand_frame(0, 31, 0);
    send_frame(0, 0, 0);
    wait_outputs(1);
    n_chk++; if (oq_data.size() != 1) $display("FAIL long_count got %0d want 1", oq_data.size()); else n_pass++;
    if (oq_data.size() >= 1) begin
      n_chk++; if (oq_len[0] !== 6'd31) $display("FAIL long_len got %0d want 31", oq_len[0]); else n_pass++;
      n_chk++; if (oq_err[0] !== 3'b100) $display("FAIL long_err got %b want 100", oq_err[0]); else n_pass++;
      n_chk++; if (oq_data[0] !== model_data(0)) $display("FAIL long_data got %h want %h", oq_data[0], model_data(0)); else n_pass++;
      n_chk++; if (oq_start[0] != fr_tlast_cyc[0] + 1) $display("FAIL long_latency got %0d want %0d", oq_start[0], fr_tlast_cyc[0] + 1); else n_pass++;
    end
  endtask

  task automatic test_backpressure_tuser();
    int hs_cyc;
    logic [335:0] exp0;
    clear_queues();
    rand_frame(0, 28, 5);
    rand_frame(1, 28, 0);
    exp0 = model_data(0);
    hs_cyc = -100;
    m_frame_ready = 1'b0;
    fork
      begin
        send_frame(0, 30, 0);
        send_frame(1, 0, 0);
      end
      begin
        for (int t = 0; t < 2000 && !m_frame_valid; t++) begin @(negedge clk); #1; end
        n_chk++; if (m_frame_valid !== 1'b1) $display("FAIL bp_valid_seen got %b want 1", m_frame_valid); else n_pass++;
        repeat (10) begin
          @(negedge clk);
          #1;
          n_chk++; if (m_frame_data !== exp0) $display("FAIL bp_stable_data got %h want %h", m_frame_data, exp0); else n_pass++;
          n_chk++; if (m_frame_error !== 3'b001) $display("FAIL bp_stable_err got %b want 001", m_frame_error); else n_pass++;
          n_chk++; if (m_frame_len !== 6'd28) $display("FAIL bp_stable_len got %0d want 28", m_frame_len); else n_pass++;
          n_chk++; if (s_eth_hdr_ready !== 1'b0 || tready !== 1'b0) $display("FAIL bp_inputs_blocked got hdr_ready=%b tready=%b want 0/0", s_eth_hdr_ready, tready); else n_pass++;
        end
        @(negedge clk);
        m_frame_ready = 1'b1;
        hs_cyc = cyc;
      end
    join
    wait_outputs(2);
    n_chk++; if (oq_data.size() != 2) $display("FAIL bp_count got %0d want 2", oq_data.size()); else n_pass++;
    if (oq_data.size() >= 2) begin
      n_chk++; if (oq_data[0] !== exp0) $display("FAIL bp_data0 got %h want %h", oq_data[0], exp0); else n_pass++;
      n_chk++; if (oq_err[0] !== 3'b001) $display("FAIL bp_err0 got %b want 001", oq_err[0]); else n_pass++;
      n_chk++; if (oq_data[1] !== model_data(1)) $display("FAIL bp_data1 got %h want %h", oq_data[1], model_data(1)); else n_pass++;
      n_chk++; if (oq_err[1] !== 3'b000) $display("FAIL bp_err1 got %b want 000", oq_err[1]); else n_pass++;
    end
    n_chk++; if (fr_hdr_cyc[1] != hs_cyc + 1) $display("FAIL bp_hdr2_accept got %0d want %0d", fr_hdr_cyc[1], hs_cyc + 1); else n_pass++;
    n_chk++; if (drv_to !== 1'b0) $display("FAIL bp_timeout got %b want 0", drv_to); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    clear_queues();
    rand_frame(0, 28, 0);
    rand_frame(1, 28, 0);
    send_frame(0, 0, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (m_frame_len !== 6'd0) $display("FAIL midrst_len got %0d want 0", m_frame_len); else n_pass++;
    n_chk++; if (m_frame_data !== 336'd0) $display("FAIL midrst_data got %h want 0", m_frame_data); else n_pass++;
    n_chk++; if (tready !== 1'b0 || m_frame_valid !== 1'b0) $display("FAIL midrst_ctrl got tready=%b valid=%b want 0/0", tready, m_frame_valid); else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++; if (oq_data.size() != 0) $display("FAIL midrst_no_output got %0d want 0", oq_data.size()); else n_pass++;
    send_frame(1, 0, 0);
    wait_outputs(1);
    n_chk++; if (oq_data.size() != 1) $display("FAIL midrst_count got %0d want 1", oq_data.size()); else n_pass++;
    if (oq_data.size() >= 1) begin
      n_chk++; if (oq_data[0] !== model_data(1)) $display("FAIL midrst_data2 got %h want %h", oq_data[0], model_data(1)); else n_pass++;
      n_chk++; if (oq_len[0] !== 6'd28) $display("FAIL midrst_len2 got %0d want 28", oq_len[0]); else n_pass++;
      n_chk++; if (oq_err[0] !== 3'b000) $display("FAIL midrst_err2 got %b want 000", oq_err[0]); else n_pass++;
    end
  endtask

  task automatic test_random();
    clear_queues();
    for (int s = 0; s < 6; s++) begin
      int n;
      n = (s == 5) ? 66 : int'($urandom_range(40, 1));
      rand_frame(s, n, ($urandom_range(2) == 0) ? int'($urandom_range(n, 1)) : 0);
    end
    drv_done = 1'b0;
    fork
      begin
        for (int s = 0; s < 6; s++) send_frame(s, 20, 0);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(negedge clk);
          m_frame_ready = ($urandom_range(3) != 0);
        end
        m_frame_ready = 1'b1;
      end
    join
    wait_outputs(6);
    n_chk++; if (oq_data.size() != 6) $display("FAIL rand_count got %0d want 6", oq_data.size()); else n_pass++;
    for (int s = 0; s < 6 && s < oq_data.size(); s++) begin
      n_chk++; if (oq_data[s] !== model_data(s)) $display("FAIL rand_data[%0d] got %h want %h", s, oq_data[s], model_data(s)); else n_pass++;
      n_chk++; if (oq_len[s] !== model_len(s)) $display("FAIL rand_len[%0d] got %0d want %0d", s, oq_len[s], model_len(s)); else n_pass++;
      n_chk++; if (oq_err[s] !== model_err(s)) $display("FAIL rand_err[%0d] got %b want %b", s, oq_err[s], model_err(s)); else n_pass++;
    end
    n_chk++; if (drv_to !== 1'b0) $display("FAIL rand_timeout got %b want 0", drv_to); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_backpressure_tuser();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
